// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the multicycle RV32I core and the memory port.
//
// One CPU request is latched in IDLE. The unit then drives a word-aligned address, byte enables
// and lane-shifted store data while holding the read or write strobe until mem_resp_i arrives.
// The load result is shifted down from its byte lane and sign- or zero-extended, and completion
// is reported with a one-cycle cpu_resp_o pulse. If memory never answers, a response timeout
// aborts the access so the core cannot stall forever.
//
// Configuration macro: MEM_ACCESS_ALIGN_CHECK_EN
//   defined   - misaligned halfword/word requests are rejected with cpu_err_o and never reach memory
//   undefined - misaligned requests are issued; lanes beyond byte 3 are dropped
//
// Parameters:
//   TIMEOUT_CYCLES  ACCESS cycles without mem_resp_i before the access is aborted (0 = never)
//
// Ports:
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   cpu_read_i       load request (sampled in IDLE only)
//   cpu_write_i      store request (sampled in IDLE only)
//   cpu_funct3_i     size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   cpu_address_i    byte address
//   cpu_wdata_i      unshifted store data
//   cpu_rdata_o      extended load result, held until the next load completes
//   cpu_resp_o       one-cycle completion pulse
//   cpu_err_o        error flag, valid with cpu_resp_o
//   mem_read_o       memory read strobe
//   mem_write_o      memory write strobe
//   mem_address_o    word-aligned address
//   mem_byte_enable_o active byte lanes
//   mem_wdata_o      lane-shifted store data
//   mem_rdata_i      memory read data, valid with mem_resp_i
//   mem_resp_i       memory completion
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_read_i,
  input  logic        cpu_write_i,
  input  logic [2:0]  cpu_funct3_i,
  input  logic [31:0] cpu_address_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_resp_o,
  output logic        cpu_err_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [3:0]  mem_byte_enable_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_resp_i
);

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3BU = 3'b100;
  localparam logic [2:0] F3HU = 3'b101;

  localparam logic [16:0] TimeoutLim = 17'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_write_q, is_write_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        f3_legal;
  logic        misaligned;
  logic        req_one;
  logic        req_both;
  logic [4:0]  lane_shift;
  logic [3:0]  byte_en;
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;
  logic        in_access;

  // Request decode (uses the live CPU inputs; only meaningful in IDLE)
  always_comb begin
    f3_legal = 1'b0;
    unique case (cpu_funct3_i)
      F3B, F3H, F3W, F3BU, F3HU: f3_legal = 1'b1;
      default:                   f3_legal = 1'b0;
    endcase
  end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  always_comb begin
    misaligned = 1'b0;
    if ((cpu_funct3_i == F3H || cpu_funct3_i == F3HU) && cpu_address_i[0]) begin
      misaligned = 1'b1;
    end else if (cpu_funct3_i == F3W && cpu_address_i[1:0] != 2'b00) begin
      misaligned = 1'b1;
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  assign req_one  = cpu_read_i ^ cpu_write_i;
  assign req_both = cpu_read_i & cpu_write_i;

  // Lane handling from the latched request so outputs stay stable through ACCESS
  assign lane_shift = {addr_q[1:0], 3'b000};

  always_comb begin
    byte_en = 4'b0000;
    case (funct3_q)
      F3B, F3BU: byte_en = 4'b0001 << addr_q[1:0];
      F3H, F3HU: byte_en = 4'b0011 << addr_q[1:0];  // upper lane falls off for addr 3
      F3W:       byte_en = 4'b1111;
      default:   byte_en = 4'b0000;
    endcase
  end

  assign rdata_shifted = mem_rdata_i >> lane_shift;

  always_comb begin
    load_ext = rdata_shifted;
    case (funct3_q)
      F3B:     load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      F3H:     load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      F3BU:    load_ext = {24'h0, rdata_shifted[7:0]};
      F3HU:    load_ext = {16'h0, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_both || ((cpu_read_i || cpu_write_i) && (!f3_legal || misaligned))) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (req_one) begin
          addr_d     = cpu_address_i;
          funct3_d   = cpu_funct3_i;
          wdata_d    = cpu_wdata_i;
          is_write_d = cpu_write_i;
          cnt_d      = '0;
          state_d    = StAccess;
        end
      end
      StAccess: begin
        if (mem_resp_i) begin
          if (!is_write_q) begin
            rdata_d = load_ext;
          end
          cnt_d   = '0;
          state_d = StDone;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (({1'b0, cnt_q} + 17'd1) == TimeoutLim) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StDone: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      funct3_q   <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      funct3_q   <= funct3_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Outputs: memory side is only active in ACCESS, so a reset or timeout drops it at once
  assign in_access         = (state_q == StAccess);
  assign mem_read_o        = in_access && !is_write_q;
  assign mem_write_o       = in_access && is_write_q;
  assign mem_address_o     = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_byte_enable_o = in_access ? byte_en : 4'b0000;
  assign mem_wdata_o       = in_access ? (wdata_q << lane_shift) : 32'h0;
  assign cpu_resp_o        = (state_q == StDone);
  assign cpu_err_o         = err_q;
  assign cpu_rdata_o       = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_read, cpu_write;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_address, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_resp, cpu_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_resp;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .cpu_read_i        (cpu_read),
    .cpu_write_i       (cpu_write),
    .cpu_funct3_i      (cpu_funct3),
    .cpu_address_i     (cpu_address),
    .cpu_wdata_i       (cpu_wdata),
    .cpu_rdata_o       (cpu_rdata),
    .cpu_resp_o        (cpu_resp),
    .cpu_err_o         (cpu_err),
    .mem_read_o        (mem_read),
    .mem_write_o       (mem_write),
    .mem_address_o     (mem_address),
    .mem_byte_enable_o (mem_byte_enable),
    .mem_wdata_o       (mem_wdata),
    .mem_rdata_i       (mem_rdata),
    .mem_resp_i        (mem_resp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    cpu_read    = rd;
    cpu_write   = wr;
    cpu_funct3  = f3;
    cpu_address = addr;
    cpu_wdata   = wd;
    tick();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  // Full access: request, check memory side, answer after `wait_cycles` extra strobe cycles
  task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int wait_cycles,
                        input logic [31:0] rd_data, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata);
    request(!wr, wr, f3, addr, wd);
    check({tag, ".rd"}, {31'h0, mem_read}, {31'h0, !wr});
    check({tag, ".wr"}, {31'h0, mem_write}, {31'h0, wr});
    check({tag, ".addr"}, mem_address, exp_addr);
    check({tag, ".be"}, {28'h0, mem_byte_enable}, {28'h0, exp_be});
    if (wr) check({tag, ".wdata"}, mem_wdata, exp_wdata);
    check({tag, ".noresp"}, {31'h0, cpu_resp}, 32'h0);
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
      check({tag, ".hold"}, {30'h0, mem_read, mem_write}, wr ? 32'h1 : 32'h2);
    end
    mem_resp  = 1'b1;
    mem_rdata = rd_data;
    tick();
    mem_resp  = 1'b0;
    mem_rdata = 32'h0;
    check({tag, ".resp"}, {31'h0, cpu_resp}, 32'h1);
    check({tag, ".err"}, {31'h0, cpu_err}, 32'h0);
    check({tag, ".rdata"}, cpu_rdata, exp_rdata);
    check({tag, ".strobe_off"}, {30'h0, mem_read, mem_write}, 32'h0);
    tick();
    check({tag, ".resp_pulse"}, {31'h0, cpu_resp}, 32'h0);
  endtask

  // Request that must complete at cycle 1 with an error and no memory activity
  task automatic reject(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] exp_rdata);
    request(rd, wr, f3, addr, 32'h0);
    check({tag, ".strobe"}, {30'h0, mem_read, mem_write}, 32'h0);
    check({tag, ".resp"}, {31'h0, cpu_resp}, 32'h1);
    check({tag, ".err"}, {31'h0, cpu_err}, 32'h1);
    check({tag, ".rdata"}, cpu_rdata, exp_rdata);
    tick();
    check({tag, ".resp_clr"}, {31'h0, cpu_resp}, 32'h0);
    check({tag, ".err_clr"}, {31'h0, cpu_err}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_funct3 = 3'b0;
    cpu_address = 32'h0; cpu_wdata = 32'h0; mem_rdata = 32'h0; mem_resp = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst.strobe", {30'h0, mem_read, mem_write}, 32'h0);
    check("rst.resp", {30'h0, cpu_resp, cpu_err}, 32'h0);
    check("rst.rdata", cpu_rdata, 32'h0);
    check("rst.addr", mem_address, 32'h0);
    check("rst.be", {28'h0, mem_byte_enable}, 32'h0);
    check("rst.wdata", mem_wdata, 32'h0);
    tick();

    //      tag    wr    f3      addr        wdata        wait rdata        maddr        be       mwdata       cpu_rdata
    access("lw",   1'b0, 3'b010, 32'h100,    32'h0,       2,   32'hDEADBEEF, 32'h100,     4'b1111, 32'h0,       32'hDEADBEEF);
    access("lb",   1'b0, 3'b000, 32'h103,    32'h0,       0,   32'h80FF1234, 32'h100,     4'b1000, 32'h0,       32'hFFFFFF80);
    access("lbu",  1'b0, 3'b100, 32'h103,    32'h0,       1,   32'h80FF1234, 32'h100,     4'b1000, 32'h0,       32'h00000080);
    access("lh",   1'b0, 3'b001, 32'h102,    32'h0,       0,   32'h80FF1234, 32'h100,     4'b1100, 32'h0,       32'hFFFF80FF);
    access("lhu",  1'b0, 3'b101, 32'h102,    32'h0,       0,   32'h80FF1234, 32'h100,     4'b1100, 32'h0,       32'h000080FF);
    access("sh",   1'b1, 3'b001, 32'h202,    32'h0000ABCD, 3,  32'h12345678, 32'h200,     4'b1100, 32'hABCD0000, 32'h000080FF);
    access("sb",   1'b1, 3'b000, 32'h401,    32'h000000A5, 0,  32'h0,        32'h400,     4'b0010, 32'h0000A500, 32'h000080FF);
    access("lbu1", 1'b0, 3'b100, 32'h501,    32'h0,       0,   32'h00007F00, 32'h500,     4'b0010, 32'h0,       32'h0000007F);
`ifndef MEM_ACCESS_ALIGN_CHECK_EN
    // Misaligned halfword at lane 3: upper byte enable is truncated away
    access("sh3",  1'b1, 3'b001, 32'h603,    32'h0000BEEF, 0,  32'h0,        32'h600,     4'b1000, 32'hEF000000, 32'h0000007F);
    access("lw2",  1'b0, 3'b010, 32'h102,    32'h0,       0,   32'hAABBCCDD, 32'h100,     4'b1111, 32'h0,       32'h0000AABB);
`else
    reject("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102, 32'h0000007F);
    reject("lh_mis", 1'b1, 1'b0, 3'b001, 32'h101, 32'h0000007F);
    access("lw2",  1'b0, 3'b010, 32'h104,    32'h0,       0,   32'hAABBCCDD, 32'h104,     4'b1111, 32'h0,       32'hAABBCCDD);
`endif

    // Timeout: strobe held exactly 4 cycles, then error response with rdata untouched
    begin
      logic [31:0] prev;
      prev = cpu_rdata;
      request(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
      for (int i = 0; i < 4; i++) begin
        check("to.strobe", {31'h0, mem_read}, 32'h1);
        check("to.noresp", {31'h0, cpu_resp}, 32'h0);
        tick();
      end
      check("to.strobe_off", {31'h0, mem_read}, 32'h0);
      check("to.resp", {31'h0, cpu_resp}, 32'h1);
      check("to.err", {31'h0, cpu_err}, 32'h1);
      check("to.rdata", cpu_rdata, prev);
      tick();
      check("to.resp_clr", {30'h0, cpu_resp, cpu_err}, 32'h0);

      reject("f3_011", 1'b1, 1'b0, 3'b011, 32'h100, prev);
      reject("f3_111", 1'b0, 1'b1, 3'b111, 32'h100, prev);
      reject("both", 1'b1, 1'b1, 3'b010, 32'h100, prev);
    end

    // Reset during ACCESS: strobes drop at the edge, no response, late mem_resp ignored
    request(1'b0, 1'b1, 3'b010, 32'h700, 32'h11223344);
    check("rstacc.pre", {31'h0, mem_write}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstacc.strobe", {30'h0, mem_read, mem_write}, 32'h0);
    check("rstacc.resp", {31'h0, cpu_resp}, 32'h0);
    check("rstacc.rdata", cpu_rdata, 32'h0);
    mem_resp  = 1'b1;
    mem_rdata = 32'hCAFEF00D;
    tick();
    mem_resp = 1'b0;
    check("rstacc.late", {30'h0, cpu_resp, cpu_err}, 32'h0);
    check("rstacc.late_rd", cpu_rdata, 32'h0);
    tick();
    check("rstacc.idle", {31'h0, cpu_resp}, 32'h0);

    // Unit still usable after the aborted access
    access("post", 1'b0, 3'b000, 32'h800, 32'h0, 0, 32'h0000007F, 32'h800, 4'b0001, 32'h0,
           32'h0000007F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
